// File: rtl/handshake_arb_src.sv
// Source-side arbiter that serialises per-channel register updates onto one four-phase CDC handshake.
// Optional watchdog (TIMEOUT_O / ERR_O ports) is enabled by defining HS_TIMEOUT_EN.
module handshake_arb_src #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_CH_NUM     = 4,
    parameter int C_TAG_WIDTH  = 2,
    parameter int C_TIMEOUT    = 1024
) (
    input  logic                                CLK_I,
    input  logic                                RST_N_I,
    input  logic [C_CH_NUM*C_DATA_WIDTH-1:0]    CH_DATA_I,
    input  logic [C_CH_NUM-1:0]                 CH_PULSE_I,
    output logic [C_CH_NUM-1:0]                 CH_PEND_O,
    output logic [C_CH_NUM-1:0]                 CH_OVWR_O,
    output logic [C_CH_NUM-1:0]                 CH_DONE_O,
    output logic [C_TAG_WIDTH+C_DATA_WIDTH-1:0] HS_DATA_O,
    output logic                                HS_SEND_O,
    input  logic                                HS_RCV_I,
    output logic                                IDLE_O
`ifdef HS_TIMEOUT_EN
    ,
    output logic                                TIMEOUT_O,
    output logic                                ERR_O
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RELEASE} state_t;

    state_t                              state_q, state_d;
    logic [C_CH_NUM-1:0]                 pend_q;
    logic [C_CH_NUM-1:0]                 ovwr_q;
    logic [C_CH_NUM-1:0]                 done_q;
    logic [C_DATA_WIDTH-1:0]             data_q [C_CH_NUM];
    logic [C_TAG_WIDTH-1:0]              ptr_q;
    logic [C_TAG_WIDTH-1:0]              grant_idx;
    logic [C_TAG_WIDTH-1:0]              cur;
    logic                                grant_vld;
    logic                                grant_go;
    logic                                ack_go;
    logic                                rel_go;
    logic                                abort;
    logic                                send_q;
    logic [C_TAG_WIDTH+C_DATA_WIDTH-1:0] hs_data_q;

    // Per-channel latch: a grant reads the old value at the same edge a new pulse overwrites it.
    for (genvar i = 0; i < C_CH_NUM; i++) begin : g_ch
        logic                    pend_r;
        logic                    ovwr_r;
        logic [C_DATA_WIDTH-1:0] data_r;
        logic                    granted;

        assign granted = grant_go && (grant_idx == C_TAG_WIDTH'(i));

        always_ff @(posedge CLK_I or negedge RST_N_I) begin
            if (!RST_N_I) begin
                pend_r <= 1'b0;
                ovwr_r <= 1'b0;
                data_r <= '0;
            end else begin
                ovwr_r <= CH_PULSE_I[i] && pend_r && !granted;
                if (CH_PULSE_I[i]) begin
                    data_r <= CH_DATA_I[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                    pend_r <= 1'b1;
                end else if (granted) begin
                    pend_r <= 1'b0;
                end
            end
        end

        assign pend_q[i] = pend_r;
        assign ovwr_q[i] = ovwr_r;
        assign data_q[i] = data_r;
    end

    // Round robin: scan upward from the channel after the last grant, wrapping at C_CH_NUM.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cur       = ptr_q;
        for (int k = 0; k < C_CH_NUM; k++) begin
            cur = (cur == C_TAG_WIDTH'(C_CH_NUM - 1)) ? '0 : cur + 1'b1;
            if (!grant_vld && pend_q[cur]) begin
                grant_vld = 1'b1;
                grant_idx = cur;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_go = 1'b0;
        ack_go   = 1'b0;
        rel_go   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Never raise send while the far side still reports the previous acknowledge.
                if (grant_vld && !HS_RCV_I) begin
                    grant_go = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (HS_RCV_I) begin
                    ack_go  = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!HS_RCV_I) begin
                    rel_go  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q   <= ST_IDLE;
            send_q    <= 1'b0;
            hs_data_q <= '0;
            ptr_q     <= C_TAG_WIDTH'(C_CH_NUM - 1);
            done_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= rel_go ? (C_CH_NUM'(1) << ptr_q) : '0;
            if (grant_go) begin
                hs_data_q <= {grant_idx, data_q[grant_idx]};
                send_q    <= 1'b1;
                ptr_q     <= grant_idx;
            end else if (ack_go || abort) begin
                send_q <= 1'b0;
            end
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;
    logic             err_q;

    assign abort = (state_q != ST_IDLE) && (cnt_q == CNT_W'(C_TIMEOUT - 1));

    // Watchdog counts cycles spent in one busy state; an abort drops the transfer without re-queueing.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= abort;
            if (abort) begin
                err_q <= 1'b1;
            end
            if ((state_q == ST_IDLE) || (state_d != state_q)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign TIMEOUT_O = tmo_q;
    assign ERR_O     = err_q;
`else
    assign abort = 1'b0;
`endif

    assign CH_PEND_O = pend_q;
    assign CH_OVWR_O = ovwr_q;
    assign CH_DONE_O = done_q;
    assign HS_DATA_O = hs_data_q;
    assign HS_SEND_O = send_q;
    assign IDLE_O    = (state_q == ST_IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_handshake_arb_src.sv
// Self-checking bench for handshake_arb_src: directed scenarios plus a randomized run against a reference model.
module tb_handshake_arb_src;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int TW = 2;
`ifdef HS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*DW-1:0]   ch_data;
    logic [N-1:0]      ch_pulse;
    logic [N-1:0]      pend, ovwr, done;
    logic [TW+DW-1:0]  hs_data;
    logic              hs_send;
    logic              hs_rcv;
    logic              idle;
`ifdef HS_TIMEOUT_EN
    logic              tmo, err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: pending set, stored values, last grant, handshake phase.
    logic [N-1:0]      m_pend, m_ovwr, m_done;
    logic [DW-1:0]     m_val [N];
    int                m_last;
    int                m_phase;   // 0 idle, 1 waiting for rcv high, 2 waiting for rcv low
    logic              m_send;
    logic [TW+DW-1:0]  m_data;

    handshake_arb_src #(
        .C_DATA_WIDTH(DW), .C_CH_NUM(N), .C_TAG_WIDTH(TW), .C_TIMEOUT(TMO)
    ) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .CH_DATA_I(ch_data), .CH_PULSE_I(ch_pulse),
        .CH_PEND_O(pend), .CH_OVWR_O(ovwr), .CH_DONE_O(done),
        .HS_DATA_O(hs_data), .HS_SEND_O(hs_send), .HS_RCV_I(hs_rcv), .IDLE_O(idle)
`ifdef HS_TIMEOUT_EN
        , .TIMEOUT_O(tmo), .ERR_O(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_ovwr = '0; m_done = '0;
        for (int i = 0; i < N; i++) m_val[i] = '0;
        m_last = N - 1; m_phase = 0; m_send = 1'b0; m_data = '0;
    endtask

    task automatic model_step();
        int ch;
        ch = -1;
        if (m_phase == 0 && m_pend != '0 && !hs_rcv) begin
            for (int k = 1; k <= N; k++) begin
                if (ch < 0 && m_pend[(m_last + k) % N]) ch = (m_last + k) % N;
            end
        end
        m_ovwr = ch_pulse & m_pend;
        if (ch >= 0) m_ovwr[ch] = 1'b0;
        m_done = '0;
        if (ch >= 0) begin
            m_data = {TW'(ch), m_val[ch]};
            m_send = 1'b1; m_pend[ch] = 1'b0; m_last = ch; m_phase = 1;
        end else if (m_phase == 1 && hs_rcv) begin
            m_send = 1'b0; m_phase = 2;
        end else if (m_phase == 2 && !hs_rcv) begin
            m_done[m_last] = 1'b1; m_phase = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (ch_pulse[i]) begin
                m_val[i] = ch_data[i*DW +: DW];
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ch_data = '0; ch_pulse = '0; hs_rcv = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (hs_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", hs_send); end
        checks++; if (hs_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", hs_data); end
        checks++; if (pend !== '0) begin errors++; $display("FAIL reset_pend: got %b want 0", pend); end
        checks++; if (ovwr !== '0 || done !== '0) begin errors++; $display("FAIL reset_pulses: ovwr %b done %b want 0", ovwr, done); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
`ifdef HS_TIMEOUT_EN
        checks++; if (tmo !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_wdog: tmo %b err %b want 0", tmo, err); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        ch_data[2*DW +: DW] = 32'hDEADBEEF; ch_pulse = 4'b0100;
        tick(); ch_pulse = '0;
        checks++; if (pend !== 4'b0100 || hs_send !== 1'b0) begin errors++; $display("FAIL single_latch: pend %b send %b want 0100/0", pend, hs_send); end
        tick();
        checks++; if (hs_send !== 1'b1 || hs_data !== 34'h2DEADBEEF) begin errors++; $display("FAIL single_grant: send %b data %h want 1/2deadbeef", hs_send, hs_data); end
        hs_rcv = 1'b1; tick();
        checks++; if (hs_send !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", hs_send); end
        hs_rcv = 1'b0; tick();
        checks++; if (done !== 4'b0100 || idle !== 1'b1) begin errors++; $display("FAIL single_done: done %b idle %b want 0100/1", done, idle); end
        tick();
        checks++; if (done !== '0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_round_robin();
        logic [TW+DW-1:0] exp_d;
        do_reset();
        for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = 32'h10 + i;
        ch_pulse = 4'b1111;
        tick(); ch_pulse = '0;
        checks++; if (pend !== 4'b1111) begin errors++; $display("FAIL rr_pend: got %b want 1111", pend); end
        for (int k = 0; k < N; k++) begin
            tick();
            exp_d = {TW'(k), 32'h10 + k};
            checks++; if (hs_send !== 1'b1 || hs_data !== exp_d || ovwr !== '0) begin
                errors++; $display("FAIL rr_grant%0d: send %b data %h ovwr %b want 1/%h/0", k, hs_send, hs_data, ovwr, exp_d);
            end
            hs_rcv = 1'b1; tick();
            hs_rcv = 1'b0; tick();
            checks++; if (done !== N'(1 << k)) begin errors++; $display("FAIL rr_done%0d: got %b want %b", k, done, N'(1 << k)); end
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle: got %b want 1", idle); end
    endtask

    task automatic test_overwrite();
        do_reset();
        ch_data[0 +: DW] = 32'h55; ch_pulse = 4'b0001;
        tick(); ch_pulse = '0;
        tick();
        ch_data[DW +: DW] = 32'hA; ch_pulse = 4'b0010;
        tick();
        checks++; if (ovwr !== '0) begin errors++; $display("FAIL ovwr_first: got %b want 0", ovwr); end
        ch_data[DW +: DW] = 32'hB;
        tick(); ch_pulse = '0;
        checks++; if (ovwr !== 4'b0010) begin errors++; $display("FAIL ovwr_pulse: got %b want 0010", ovwr); end
        tick();
        checks++; if (ovwr !== '0) begin errors++; $display("FAIL ovwr_once: got %b want 0", ovwr); end
        hs_rcv = 1'b1; tick();
        hs_rcv = 1'b0; tick();
        tick();
        checks++; if (hs_send !== 1'b1 || hs_data !== {2'd1, 32'hB}) begin errors++; $display("FAIL ovwr_data: send %b data %h want 1/10000000b", hs_send, hs_data); end
        hs_rcv = 1'b1; tick();
        hs_rcv = 1'b0; tick();
        checks++; if (done !== 4'b0010 || pend !== '0) begin errors++; $display("FAIL ovwr_done: done %b pend %b want 0010/0", done, pend); end
        tick();
        checks++; if (hs_send !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL ovwr_single_xfer: send %b idle %b want 0/1", hs_send, idle); end
    endtask

    task automatic test_protocol_hold();
        logic [TW+DW-1:0] exp_d;
        do_reset();
        ch_data[DW +: DW] = 32'h5; ch_pulse = 4'b0010;
        tick(); ch_pulse = '0;
        tick();
        exp_d = {2'd1, 32'h5};
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++; if (hs_send !== 1'b1 || hs_data !== exp_d) begin errors++; $display("FAIL hold_send c%0d: send %b data %h want 1/%h", c, hs_send, hs_data, exp_d); end
        end
        hs_rcv = 1'b1; tick();
        ch_data[3*DW +: DW] = 32'h33; ch_pulse = 4'b1000;
        tick(); ch_pulse = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (hs_send !== 1'b0 || done !== '0) begin errors++; $display("FAIL hold_release c%0d: send %b done %b want 0/0", c, hs_send, done); end
        end
        hs_rcv = 1'b0; tick();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL hold_done: got %b want 0010", done); end
        tick();
        checks++; if (hs_send !== 1'b1 || hs_data !== {2'd3, 32'h33}) begin errors++; $display("FAIL hold_next: send %b data %h want 1/300000033", hs_send, hs_data); end
        hs_rcv = 1'b1; tick();
        hs_rcv = 1'b0; tick();
        hs_rcv = 1'b1; ch_data[0 +: DW] = 32'h99; ch_pulse = 4'b0001;
        tick(); ch_pulse = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (hs_send !== 1'b0 || pend !== 4'b0001) begin errors++; $display("FAIL idle_rcv_high c%0d: send %b pend %b want 0/0001", c, hs_send, pend); end
        end
        hs_rcv = 1'b0; tick();
        checks++; if (hs_send !== 1'b1 || hs_data !== {2'd0, 32'h99}) begin errors++; $display("FAIL idle_rcv_grant: send %b data %h want 1/000000099", hs_send, hs_data); end
        hs_rcv = 1'b1; tick();
        hs_rcv = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ch_data[DW +: DW] = 32'h1; ch_data[3*DW +: DW] = 32'h3; ch_pulse = 4'b1010;
        tick(); ch_pulse = '0;
        tick();
        checks++; if (hs_send !== 1'b1 || pend !== 4'b1000) begin errors++; $display("FAIL arst_setup: send %b pend %b want 1/1000", hs_send, pend); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hs_send !== 1'b0 || pend !== '0 || idle !== 1'b1) begin errors++; $display("FAIL arst_async: send %b pend %b idle %b want 0/0/1", hs_send, pend, idle); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

`ifdef HS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        ch_data[0 +: DW] = 32'h1; ch_pulse = 4'b0001;
        tick(); ch_pulse = '0;
        tick();
        ch_data[3*DW +: DW] = 32'h3C; ch_pulse = 4'b1000;
        for (int c = 0; c < 15; c++) begin
            tick(); ch_pulse = '0;
            checks++; if (hs_send !== 1'b1) begin errors++; $display("FAIL tmo_hold c%0d: got %b want 1", c, hs_send); end
        end
        tick();
        checks++; if (hs_send !== 1'b0 || tmo !== 1'b1 || err !== 1'b1 || done !== '0) begin
            errors++; $display("FAIL tmo_abort: send %b tmo %b err %b done %b want 0/1/1/0", hs_send, tmo, err, done);
        end
        tick();
        checks++; if (tmo !== 1'b0 || err !== 1'b1 || hs_send !== 1'b1 || hs_data !== {2'd3, 32'h3C}) begin
            errors++; $display("FAIL tmo_after: tmo %b err %b send %b data %h want 0/1/1/30000003c", tmo, err, hs_send, hs_data);
        end
    endtask
`endif

    task automatic test_random();
        int wait_cnt;
        do_reset();
        wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                ch_pulse[i] = ($urandom_range(0, 5) == 0);
                ch_data[i*DW +: DW] = $urandom;
            end
            wait_cnt++;
            if (hs_send && !hs_rcv) begin
                if ($urandom_range(0, 2) == 0 || wait_cnt > 8) begin hs_rcv = 1'b1; wait_cnt = 0; end
            end else if (!hs_send && hs_rcv) begin
                if ($urandom_range(0, 2) == 0 || wait_cnt > 8) begin hs_rcv = 1'b0; wait_cnt = 0; end
            end else if (!hs_send && !hs_rcv && $urandom_range(0, 30) == 0) begin
                hs_rcv = 1'b1; wait_cnt = 0;
            end
            tick();
            checks++; if (hs_send !== m_send) begin errors++; $display("FAIL rnd_send c%0d: got %b want %b", c, hs_send, m_send); end
            checks++; if (hs_data !== m_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, hs_data, m_data); end
            checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pend c%0d: got %b want %b", c, pend, m_pend); end
            checks++; if (ovwr !== m_ovwr) begin errors++; $display("FAIL rnd_ovwr c%0d: got %b want %b", c, ovwr, m_ovwr); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done c%0d: got %b want %b", c, done, m_done); end
            checks++; if (idle !== (m_phase == 0 && m_pend == '0)) begin errors++; $display("FAIL rnd_idle c%0d: got %b want %b", c, idle, (m_phase == 0 && m_pend == '0)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ch_data = '0; ch_pulse = '0; hs_rcv = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_overwrite();
        test_protocol_hold();
        test_async_reset();
`ifdef HS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
